// File: rtl/sbox_inverse_affine_if.sv
// Byte-lane handshake bundle for the sequential AES SubBytes engine.
// dec_mode exists only when SBOX_DECRYPT_EN is defined.
interface sbox_inverse_affine_if;
`ifdef SBOX_DECRYPT_EN
    logic       dec_mode;
`endif
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       busy;

    modport master (
`ifdef SBOX_DECRYPT_EN
        output dec_mode,
`endif
        output in_valid,
        input  in_ready,
        output in_byte,
        input  out_valid,
        output out_ready,
        input  out_byte,
        input  busy
    );

    modport slave (
`ifdef SBOX_DECRYPT_EN
        input  dec_mode,
`endif
        input  in_valid,
        output in_ready,
        input  in_byte,
        output out_valid,
        input  out_ready,
        output out_byte,
        output busy
    );
endinterface

// File: rtl/sbox_inverse_affine.sv
// One-byte AES S-box: GF(2^8) inverse as x^254 (one reduced multiply per cycle),
// then the affine transform. SBOX_DECRYPT_EN adds inverse SubBytes via dec_mode.
module sbox_inverse_affine #(
    parameter logic [8:0] POLY     = 9'h11B,
    parameter logic [7:0] AFFINE_C = 8'h63
) (
    input logic                   clk,
    input logic                   rst,
    sbox_inverse_affine_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQ,
        S_MUL,
        S_AFF,
        S_HOLD
    } state_t;

    localparam logic [3:0] LAST_OP = 4'd12;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [7:0] r_q, r_d;
    logic [3:0] op_cnt_q, op_cnt_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       busy_q, busy_d;

    logic [7:0] mul_b;
    logic [7:0] prod;
    logic [7:0] aff_byte;
    logic [7:0] capture_byte;
    logic [7:0] result_byte;

    // Carry-less 8x8 product followed by reduction modulo POLY.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ ({7'b0, a} << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ ({6'b0, POLY} << (k - 8));
        end
        return p[7:0];
    endfunction

    // SQ squares the running power, MUL folds in the original x.
    assign mul_b = (state_q == S_MUL) ? x_q : r_q;
    assign prod  = gf_mul(r_q, mul_b);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_aff
            assign aff_byte[gi] = r_q[gi] ^ r_q[(gi + 4) % 8] ^ r_q[(gi + 5) % 8]
                                ^ r_q[(gi + 6) % 8] ^ r_q[(gi + 7) % 8] ^ AFFINE_C[gi];
        end
    endgenerate

`ifdef SBOX_DECRYPT_EN
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    logic       dec_q, dec_d;
    logic [7:0] inv_aff_byte;

    // Inverse affine is applied on capture so the same x^254 chain finishes the job.
    generate
        for (gi = 0; gi < 8; gi++) begin : g_inv_aff
            assign inv_aff_byte[gi] = bus.in_byte[(gi + 2) % 8] ^ bus.in_byte[(gi + 5) % 8]
                                    ^ bus.in_byte[(gi + 7) % 8] ^ INV_AFFINE_C[gi];
        end
    endgenerate

    assign capture_byte = bus.dec_mode ? inv_aff_byte : bus.in_byte;
    assign result_byte  = dec_q ? r_q : aff_byte;
`else
    assign capture_byte = bus.in_byte;
    assign result_byte  = aff_byte;
`endif

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        r_d         = r_q;
        op_cnt_d    = op_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        busy_d      = busy_q;
`ifdef SBOX_DECRYPT_EN
        dec_d       = dec_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d        = capture_byte;
                    r_d        = capture_byte;
                    op_cnt_d   = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SQ;
`ifdef SBOX_DECRYPT_EN
                    dec_d      = bus.dec_mode;
`endif
                end
            end
            S_SQ: begin
                r_d      = prod;
                op_cnt_d = op_cnt_q + 4'd1;
                state_d  = (op_cnt_q == LAST_OP) ? S_AFF : S_MUL;
            end
            S_MUL: begin
                r_d      = prod;
                op_cnt_d = op_cnt_q + 4'd1;
                state_d  = S_SQ;
            end
            S_AFF: begin
                out_byte_d  = result_byte;
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            r_q         <= '0;
            op_cnt_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            busy_q      <= 1'b0;
`ifdef SBOX_DECRYPT_EN
            dec_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            r_q         <= r_d;
            op_cnt_q    <= op_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            busy_q      <= busy_d;
`ifdef SBOX_DECRYPT_EN
            dec_q       <= dec_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sbox_inverse_affine.sv
// Scoreboard bench for sbox_inverse_affine: directed bytes, backpressure, busy drop,
// mid-operation reset and a full 256-value sweep (round trip when SBOX_DECRYPT_EN).
module tb_sbox_inverse_affine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_inverse_affine_if bus ();

    sbox_inverse_affine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
        int         acc;
    } txn_t;

    txn_t sb[$];

    logic [7:0] sbox_tbl [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one byte; the expected result enters the scoreboard at the accept edge.
    task automatic send(input logic [7:0] b, input logic [7:0] exp, input logic dec);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.in_ready) begin
            chk("send_timeout", 32'd0, 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
`ifdef SBOX_DECRYPT_EN
        bus.dec_mode = dec;
`else
        if (dec) $display("note: dec request ignored in forward-only build");
`endif
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back('{din: b, exp: exp, acc: cyc});
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((sb.size() != 0 || bus.out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: latency on the rising edge of out_valid, data/stability while valid,
    // pop and compare on every accepted output.
    initial begin
        logic prev_valid;
        txn_t t;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!prev_valid) chk("latency", 32'(cyc - sb[0].acc), 32'd14);
                    chk("out_byte", {24'd0, bus.out_byte}, {24'd0, sb[0].exp});
                    chk("in_ready_while_valid", {31'd0, bus.in_ready}, 32'd0);
                    chk("busy_while_valid", {31'd0, bus.busy}, 32'd1);
                    if (bus.out_ready) begin
                        t = sb.pop_front();
                        $display("txn in=%h out=%h exp=%h lat_from=%0d", t.din, bus.out_byte, t.exp, t.acc);
                    end
                end
                prev_valid = 1'b1;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b0;
`ifdef SBOX_DECRYPT_EN
        bus.dec_mode  = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        chk("rst_busy",      {31'd0, bus.busy},      32'd0);
        chk("rst_out_byte",  {24'd0, bus.out_byte},  32'd0);

        // Directed forward vectors
        bus.out_ready = 1'b1;
        send(8'h00, 8'h63, 1'b0);
        send(8'h01, 8'h7C, 1'b0);
        send(8'h53, 8'hED, 1'b0);
        send(8'hFF, 8'h16, 1'b0);
        wait_drain();

        // Backpressure
        bus.out_ready = 1'b0;
        send(8'h53, 8'hED, 1'b0);
        begin
            int guard = 0;
            while (!bus.out_valid && guard < 30) begin
                @(posedge clk); #1;
                guard++;
            end
        end
        chk("bp_valid_seen", {31'd0, bus.out_valid}, 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_byte",  {24'd0, bus.out_byte},  32'h0000_00ED);
            chk("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
        chk("bp_release_busy",  {31'd0, bus.busy},      32'd0);
        wait_drain();

        // in_valid while busy must be ignored
        send(8'h01, 8'h7C, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'hAA;
        repeat (10) begin
            @(posedge clk); #1;
            chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        repeat (20) @(posedge clk);
        #1 chk("busy_no_extra", {31'd0, bus.out_valid}, 32'd0);

        // Reset at accept edge + 6 aborts the byte
        send(8'hFF, 8'h16, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        chk("abort_busy",     {31'd0, bus.busy},      32'd0);
        chk("abort_in_ready", {31'd0, bus.in_ready},  32'd1);
        chk("abort_valid",    {31'd0, bus.out_valid}, 32'd0);
        repeat (20) @(posedge clk);
        #1 chk("abort_no_output", {31'd0, bus.out_valid}, 32'd0);
        send(8'h00, 8'h63, 1'b0);
        wait_drain();

        // Full forward sweep
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send(b, sbox_tbl[i], 1'b0);
        end
        wait_drain();

`ifdef SBOX_DECRYPT_EN
        send(8'hED, 8'h53, 1'b1);
        send(8'h63, 8'h00, 1'b1);
        send(8'h53, 8'hED, 1'b0);
        wait_drain();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send(b, sbox_tbl[i], 1'b0);
            send(sbox_tbl[i], b, 1'b1);
        end
        wait_drain();
`endif

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
